// File: rtl/qspi_xfer_sequencer_pkg.sv
// Shared types for the QSPI transfer sequencer: lane modes, transfer phases and
// the beat arithmetic used to size each shifting phase.
package qspi_xfer_sequencer_pkg;

   typedef enum logic [1:0] {
      LANE_X1   = 2'b00,
      LANE_X2   = 2'b01,
      LANE_X4   = 2'b10,
      LANE_RSVD = 2'b11
   } lane_mode_e;

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_CMD_LD  = 3'd1,
      PH_CMD     = 3'd2,
      PH_ADDR_LD = 3'd3,
      PH_ADDR    = 3'd4,
      PH_DUMMY   = 3'd5,
      PH_DATA    = 3'd6,
      PH_DONE    = 3'd7
   } phase_e;

   // Wide enough for 256 data bytes on a single lane (2048 beats)
   localparam int BEAT_W = 12;

   // Reserved mode falls back to a single lane
   function automatic logic [2:0] lanes_of(lane_mode_e m);
      case (m)
         LANE_X2: return 3'd2;
         LANE_X4: return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [BEAT_W-1:0] beats_of(logic [BEAT_W-1:0] bits, lane_mode_e m);
      case (lanes_of(m))
         3'd2:    return bits >> 1;
         3'd4:    return bits >> 2;
         default: return bits;
      endcase
   endfunction

   // One-hot lane select ordered {x4, x2, x1}
   function automatic logic [2:0] lane_sel_of(lane_mode_e m);
      return {lanes_of(m) == 3'd4, lanes_of(m) == 3'd2, lanes_of(m) == 3'd1};
   endfunction

endpackage

// File: rtl/qspi_xfer_sequencer_sclk_gen.sv
// SCLK generator: divides HCLK by CLK_DIV per half-period and flags the edge
// that the next clock will produce so the sequencer can register its pulses.
module qspi_xfer_sequencer_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   logic          tc;

   assign tc   = (div_cnt == DW'(CLK_DIV - 1));
   assign rise = en & ~clr & tc & ~sclk;
   assign fall = en & ~clr & tc & sclk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (clr) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (en) begin
         if (tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/qspi_xfer_sequencer.sv
// QSPI transfer-phase sequencer: walks CMD -> ADDR -> DUMMY -> DATA, drives CS#/SCLK
// and issues the load/shift/sample pulses and lane selects for the shift registers.
module qspi_xfer_sequencer
   import qspi_xfer_sequencer_pkg::*;
#(
   parameter int  CLK_DIV        = 2,
   parameter int  CS_HIGH_MIN    = 2,
   parameter int  MAX_DATA_BYTES = 256,
   localparam int LW             = $clog2(MAX_DATA_BYTES + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [7:0]    cmd_in,
   input  logic [31:0]   addr_in,
   input  logic          addrOF4B_in,
   input  logic [1:0]    cmd_mode_in,
   input  logic [1:0]    addr_mode_in,
   input  logic [1:0]    data_mode_in,
   input  logic [4:0]    dummy_cycles_in,
   input  logic [LW-1:0] data_len_in,
   output logic          qspi_cs_n,
   output logic          qspi_sclk,
   output logic          cmd_load,
   output logic          addr_load,
   output logic [7:0]    cmd_data_out,
   output logic [31:0]   addr_data_out,
   output logic          addrOF4B_out,
   output logic          shift_en,
   output logic          sample_en,
   output logic          use_1_io_lines_out,
   output logic          use_2_io_lines_out,
   output logic          use_4_io_lines_out,
   output logic [2:0]    phase_out,
   output logic          busy,
   output logic          done
);

   localparam int HW = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;

   phase_e              state, nxt_phase;
   lane_mode_e          cmd_mode_r, addr_mode_r, data_mode_r;
   logic [31:0]         addr_r;
   logic                four_b_r;
   logic [4:0]          dummy_r;
   logic [BEAT_W-1:0]   data_beats_r, beat_cnt, beats_total;
   logic [HW-1:0]       hold_cnt;
   logic [2:0]          lane_sel;
   logic                accept, shifting, last_beat, rise, fall;

   assign accept   = (state == PH_IDLE) && start && !abort;
   assign shifting = (state == PH_CMD) || (state == PH_ADDR) ||
                     (state == PH_DUMMY) || (state == PH_DATA);

   // Transfer configuration is frozen at accept; no reset needed on these
   always_ff @(posedge clk) begin
      if (accept) begin
         cmd_mode_r   <= lane_mode_e'(cmd_mode_in);
         addr_mode_r  <= lane_mode_e'(addr_mode_in);
         data_mode_r  <= lane_mode_e'(data_mode_in);
         addr_r       <= addr_in;
         four_b_r     <= addrOF4B_in;
         dummy_r      <= dummy_cycles_in;
         data_beats_r <= beats_of(BEAT_W'({data_len_in, 3'b000}), lane_mode_e'(data_mode_in));
      end
   end

   always_comb begin
      beats_total = '0;
      nxt_phase   = PH_DONE;
      case (state)
         PH_CMD: begin
            beats_total = beats_of(BEAT_W'(8), cmd_mode_r);
            nxt_phase   = PH_ADDR_LD;
         end
         PH_ADDR: begin
            beats_total = beats_of(four_b_r ? BEAT_W'(32) : BEAT_W'(24), addr_mode_r);
            nxt_phase   = (dummy_r != '0) ? PH_DUMMY :
                          (data_beats_r != '0) ? PH_DATA : PH_DONE;
         end
         PH_DUMMY: begin
            beats_total = BEAT_W'(dummy_r);
            nxt_phase   = (data_beats_r != '0) ? PH_DATA : PH_DONE;
         end
         PH_DATA: beats_total = data_beats_r;
         default: ;
      endcase
   end

   assign last_beat = (beat_cnt == beats_total - 1'b1);

   qspi_xfer_sequencer_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (shifting),
      .clr   (~shifting | abort),
      .sclk  (qspi_sclk),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= PH_IDLE;
         qspi_cs_n     <= 1'b1;
         cmd_load      <= 1'b0;
         addr_load     <= 1'b0;
         shift_en      <= 1'b0;
         sample_en     <= 1'b0;
         done          <= 1'b0;
         busy          <= 1'b0;
         cmd_data_out  <= '0;
         addr_data_out <= '0;
         addrOF4B_out  <= 1'b0;
         lane_sel      <= 3'b001;
         beat_cnt      <= '0;
         hold_cnt      <= '0;
      end else begin
         cmd_load  <= 1'b0;
         addr_load <= 1'b0;
         shift_en  <= 1'b0;
         sample_en <= 1'b0;
         done      <= 1'b0;
         case (state)
            PH_IDLE: begin
               if (accept) begin
                  state        <= PH_CMD_LD;
                  qspi_cs_n    <= 1'b0;
                  cmd_load     <= 1'b1;
                  cmd_data_out <= cmd_in;
                  busy         <= 1'b1;
                  lane_sel     <= lane_sel_of(lane_mode_e'(cmd_mode_in));
                  beat_cnt     <= '0;
               end
            end
            PH_DONE: begin
               if (hold_cnt == HW'(CS_HIGH_MIN - 1)) begin
                  state    <= PH_IDLE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               if (abort) begin
                  state     <= PH_DONE;
                  qspi_cs_n <= 1'b1;
                  lane_sel  <= 3'b001;
                  beat_cnt  <= '0;
                  hold_cnt  <= '0;
               end else if (state == PH_CMD_LD) begin
                  state <= PH_CMD;
               end else if (state == PH_ADDR_LD) begin
                  state <= PH_ADDR;
               end else begin
                  if (rise && state == PH_DATA)
                     sample_en <= 1'b1;
                  // The last falling edge hands over to the next phase instead of shifting
                  if (fall) begin
                     if (!last_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        shift_en <= 1'b1;
                     end else begin
                        beat_cnt <= '0;
                        state    <= nxt_phase;
                        case (nxt_phase)
                           PH_ADDR_LD: begin
                              addr_load     <= 1'b1;
                              addr_data_out <= addr_r;
                              addrOF4B_out  <= four_b_r;
                              lane_sel      <= lane_sel_of(addr_mode_r);
                           end
                           PH_DUMMY, PH_DATA: lane_sel <= lane_sel_of(data_mode_r);
                           default: begin
                              qspi_cs_n <= 1'b1;
                              lane_sel  <= 3'b001;
                              hold_cnt  <= '0;
                           end
                        endcase
                     end
                  end
               end
            end
         endcase
      end
   end

   assign use_1_io_lines_out = lane_sel[0];
   assign use_2_io_lines_out = lane_sel[1];
   assign use_4_io_lines_out = lane_sel[2];
   assign phase_out          = state;

endmodule

// File: tb/tb_qspi_xfer_sequencer.sv
// Scoreboard bench for qspi_xfer_sequencer: expected per-transfer activity is derived
// from lane/length arithmetic and checked by a monitor when each transfer completes.
module tb_qspi_xfer_sequencer;
   import qspi_xfer_sequencer_pkg::*;

   localparam int CLK_DIV     = 2;
   localparam int CS_HIGH_MIN = 2;
   localparam int LW          = 9;

   logic          clk = 1'b0;
   logic          rst_n, start, abort;
   logic [7:0]    cmd_in;
   logic [31:0]   addr_in;
   logic          addrOF4B_in;
   logic [1:0]    cmd_mode_in, addr_mode_in, data_mode_in;
   logic [4:0]    dummy_cycles_in;
   logic [LW-1:0] data_len_in;
   logic          qspi_cs_n, qspi_sclk, cmd_load, addr_load, addrOF4B_out;
   logic [7:0]    cmd_data_out;
   logic [31:0]   addr_data_out;
   logic          shift_en, sample_en, use_1, use_2, use_4, busy, done;
   logic [2:0]    phase_out;

   qspi_xfer_sequencer #(
      .CLK_DIV(CLK_DIV), .CS_HIGH_MIN(CS_HIGH_MIN), .MAX_DATA_BYTES(256)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cmd_in(cmd_in), .addr_in(addr_in), .addrOF4B_in(addrOF4B_in),
      .cmd_mode_in(cmd_mode_in), .addr_mode_in(addr_mode_in), .data_mode_in(data_mode_in),
      .dummy_cycles_in(dummy_cycles_in), .data_len_in(data_len_in),
      .qspi_cs_n(qspi_cs_n), .qspi_sclk(qspi_sclk), .cmd_load(cmd_load), .addr_load(addr_load),
      .cmd_data_out(cmd_data_out), .addr_data_out(addr_data_out), .addrOF4B_out(addrOF4B_out),
      .shift_en(shift_en), .sample_en(sample_en),
      .use_1_io_lines_out(use_1), .use_2_io_lines_out(use_2), .use_4_io_lines_out(use_4),
      .phase_out(phase_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          aborted;
      int          cmd_rises, addr_rises, dummy_rises, data_rises;
      int          shifts;
      logic [2:0]  cmd_lane, addr_lane, data_lane;
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic        four_b;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic timeout_fail(input string what);
      n_checks++;
      $display("FAIL %s: got timeout, required event within bound", what);
   endtask

   // Reference model: beats per phase = bits / lanes, one shift per beat except the last
   function automatic int lanes(input logic [1:0] m);
      return (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
   endfunction

   function automatic logic [2:0] onehot(input int l);
      return (l == 4) ? 3'b100 : (l == 2) ? 3'b010 : 3'b001;
   endfunction

   function automatic exp_t model(input logic [7:0] c, input logic [31:0] a, input logic fb,
                                  input logic [1:0] cm, input logic [1:0] am, input logic [1:0] dm,
                                  input int dc, input int len, input bit ab);
      exp_t e;
      e.aborted     = ab;
      e.cmd_rises   = 8 / lanes(cm);
      e.addr_rises  = (fb ? 32 : 24) / lanes(am);
      e.dummy_rises = dc;
      e.data_rises  = len * 8 / lanes(dm);
      e.shifts      = (e.cmd_rises - 1) + (e.addr_rises - 1) +
                      ((dc > 0) ? dc - 1 : 0) + ((e.data_rises > 0) ? e.data_rises - 1 : 0);
      e.cmd_lane    = onehot(lanes(cm));
      e.addr_lane   = onehot(lanes(am));
      e.data_lane   = onehot(lanes(dm));
      e.cmd         = c;
      e.addr        = a;
      e.four_b      = fb;
      return e;
   endfunction

   // Monitor observations for the transfer in flight
   int          obs_rise[8], obs_shift[8];
   logic [2:0]  obs_lane[8];
   bit          obs_lane_set[8];
   int          obs_samp, obs_cmd_load, obs_addr_load, obs_done_cyc, obs_cs_bad, obs_lane_bad;
   logic [7:0]  obs_cmd;
   logic [31:0] obs_addr;
   logic        obs_4b;
   logic        prev_sclk = 1'b0;

   task automatic clear_obs();
      for (int i = 0; i < 8; i++) begin
         obs_rise[i] = 0; obs_shift[i] = 0; obs_lane[i] = 3'b000; obs_lane_set[i] = 1'b0;
      end
      obs_samp = 0; obs_cmd_load = 0; obs_addr_load = 0; obs_done_cyc = 0;
      obs_cs_bad = 0; obs_lane_bad = 0; obs_cmd = 8'h00; obs_addr = 32'h0; obs_4b = 1'b0;
   endtask

   task automatic compare(input exp_t e);
      int tot_shift;
      tot_shift = 0;
      for (int i = 0; i < 8; i++) tot_shift += obs_shift[i];
      chk("cmd_load_count", obs_cmd_load, 1);
      chk("addr_load_count", obs_addr_load, 1);
      chk("cmd_sclk_rises", obs_rise[PH_CMD], e.cmd_rises);
      chk("cs_n_level", obs_cs_bad, 0);
      chk("done_phase_cycles", obs_done_cyc, CS_HIGH_MIN);
      chk("sclk_rises_in_done", obs_rise[PH_DONE], 0);
      chk("shift_en_in_done", obs_shift[PH_DONE], 0);
      chk("cmd_lane", obs_lane[PH_CMD], e.cmd_lane);
      chk("addr_ld_lane", obs_lane[PH_ADDR_LD], e.addr_lane);
      if (e.aborted) begin
         chk("abort_sample_en", obs_samp, 0);
      end else begin
         chk("cmd_value", obs_cmd, e.cmd);
         chk("addr_value", obs_addr, e.addr);
         chk("addr_4b", obs_4b, e.four_b);
         chk("addr_sclk_rises", obs_rise[PH_ADDR], e.addr_rises);
         chk("addr_shift_en", obs_shift[PH_ADDR], e.addr_rises - 1);
         chk("dummy_sclk_rises", obs_rise[PH_DUMMY], e.dummy_rises);
         chk("data_sclk_rises", obs_rise[PH_DATA], e.data_rises);
         chk("total_shift_en", tot_shift, e.shifts);
         chk("sample_en_count", obs_samp, e.data_rises);
         chk("cmd_ld_lane", obs_lane[PH_CMD_LD], e.cmd_lane);
         chk("addr_lane", obs_lane[PH_ADDR], e.addr_lane);
         chk("lane_stable_onehot", obs_lane_bad, 0);
         if (e.data_rises > 0) chk("data_lane", obs_lane[PH_DATA], e.data_lane);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         clear_obs();
         prev_sclk = 1'b0;
      end else begin
         if (qspi_sclk && !prev_sclk) obs_rise[phase_out]++;
         prev_sclk = qspi_sclk;
         if (shift_en) obs_shift[phase_out]++;
         if (sample_en) obs_samp++;
         if (cmd_load) begin obs_cmd_load++; obs_cmd = cmd_data_out; end
         if (addr_load) begin obs_addr_load++; obs_addr = addr_data_out; obs_4b = addrOF4B_out; end
         if (phase_out == PH_DONE) begin
            obs_done_cyc++;
            if (!qspi_cs_n) obs_cs_bad++;
         end else if (phase_out != PH_IDLE) begin
            if (qspi_cs_n) obs_cs_bad++;
            if ($countones({use_4, use_2, use_1}) != 1) obs_lane_bad++;
            if (!obs_lane_set[phase_out]) begin
               obs_lane_set[phase_out] = 1'b1;
               obs_lane[phase_out]     = {use_4, use_2, use_1};
            end else if (obs_lane[phase_out] != {use_4, use_2, use_1}) begin
               obs_lane_bad++;
            end
         end
         if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else compare(exp_q.pop_front());
            clear_obs();
         end
      end
   end

   task automatic wait_phase(input logic [2:0] ph, input string what);
      int g;
      g = 0;
      while (phase_out != ph && g < 20000) begin @(posedge clk); #1; g++; end
      if (g >= 20000) timeout_fail(what);
   endtask

   task automatic do_xfer(input logic [7:0] c, input logic [31:0] a, input logic fb,
                          input logic [1:0] cm, input logic [1:0] am, input logic [1:0] dm,
                          input int dc, input int len, input int abort_after);
      int g;
      wait_phase(PH_IDLE, "idle_before_start");
      cmd_in = c; addr_in = a; addrOF4B_in = fb;
      cmd_mode_in = cm; addr_mode_in = am; data_mode_in = dm;
      dummy_cycles_in = dc[4:0]; data_len_in = len[LW-1:0];
      start = 1'b1;
      exp_q.push_back(model(c, a, fb, cm, am, dm, dc, len, abort_after >= 0));
      @(posedge clk); #1;
      start = 1'b0;
      // Config must be held internally, so disturb the inputs right away
      cmd_in = 8'($urandom); addr_in = $urandom; addrOF4B_in = 1'($urandom);
      cmd_mode_in = 2'($urandom); addr_mode_in = 2'($urandom); data_mode_in = 2'($urandom);
      dummy_cycles_in = 5'($urandom); data_len_in = LW'($urandom);
      chk("cmd_load_latency", cmd_load, 1);
      chk("busy_after_start", busy, 1);
      if (abort_after >= 0) begin
         wait_phase(PH_ADDR, "reach_addr");
         repeat (abort_after) @(posedge clk);
         #1;
         abort = 1'b1; start = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
         chk("abort_next_phase", phase_out, PH_DONE);
         chk("abort_sclk", qspi_sclk, 0);
         chk("abort_shift_en", shift_en, 0);
         chk("abort_cs_n", qspi_cs_n, 1);
         @(posedge clk); #1;
         start = 1'b0;
      end
      g = 0;
      do begin @(negedge clk); g++; end while (!done && g < 20000);
      if (!done) timeout_fail("done_pulse");
      if (abort_after >= 0) begin
         @(posedge clk); #1;
         chk("start_ignored_while_busy", phase_out, PH_IDLE);
         chk("busy_after_done", busy, 0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cmd_in = '0; addr_in = '0; addrOF4B_in = 1'b0;
      cmd_mode_in = '0; addr_mode_in = '0; data_mode_in = '0;
      dummy_cycles_in = '0; data_len_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", qspi_cs_n, 1);
      chk("rst_sclk", qspi_sclk, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lanes", {use_4, use_2, use_1}, 3'b001);
      chk("rst_phase", phase_out, PH_IDLE);
      chk("rst_addr_data", addr_data_out, 0);
      chk("rst_addr4b", addrOF4B_out, 0);
      chk("rst_pulses", {cmd_load, addr_load, shift_en, sample_en}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // start together with abort in IDLE is dropped
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle_phase", phase_out, PH_IDLE);
      chk("start_abort_idle_busy", busy, 0);
      chk("start_abort_idle_load", cmd_load, 0);

      do_xfer(8'h03, 32'h0012_3456, 1'b0, 2'b00, 2'b00, 2'b00, 0, 1, -1);
      do_xfer(8'hEB, 32'hA5A5_A5A5, 1'b1, 2'b00, 2'b10, 2'b10, 8, 4, -1);
      do_xfer(8'h0B, 32'h00AB_CDEF, 1'b0, 2'b01, 2'b11, 2'b01, 0, 2, -1);
      do_xfer(8'h0B, 32'h89AB_CDEF, 1'b1, 2'b00, 2'b11, 2'b00, 3, 0, -1);
      do_xfer(8'h02, 32'h0000_1000, 1'b0, 2'b00, 2'b00, 2'b00, 0, 0, -1);
      do_xfer(8'h6B, 32'h0040_0000, 1'b0, 2'b10, 2'b10, 2'b10, 0, 256, -1);
      do_xfer(8'h03, 32'h0000_0001, 1'b0, 2'b00, 2'b00, 2'b00, 1, 256, -1);
      do_xfer(8'h3B, 32'h1234_5678, 1'b1, 2'b00, 2'b00, 2'b01, 0, 4, 5);

      for (int i = 0; i < 24; i++) begin
         int dc, len;
         dc  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
         len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
         do_xfer(8'($urandom), $urandom, 1'($urandom), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), dc, len,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : -1);
      end

      // Asynchronous reset in the middle of the data phase
      wait_phase(PH_IDLE, "idle_before_reset_xfer");
      cmd_in = 8'h03; addr_in = 32'h0000_0100; addrOF4B_in = 1'b0;
      cmd_mode_in = 2'b00; addr_mode_in = 2'b00; data_mode_in = 2'b00;
      dummy_cycles_in = 5'd0; data_len_in = 9'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_phase(PH_DATA, "reach_data");
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cs_n", qspi_cs_n, 1);
      chk("async_rst_sclk", qspi_sclk, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_phase", phase_out, PH_IDLE);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_xfer(8'hBB, 32'h00C0_FFEE, 1'b0, 2'b01, 2'b01, 2'b01, 4, 3, -1);

      repeat (4) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
